// File: rtl/asrv32_dmem_interface.sv
// Memory-access stage bridge to a Wishbone-classic data bus: one bus cycle per load/store,
// right-aligned load data, pipeline stall until completion, fault or timeout.
module asrv32_dmem_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_fault,
  output logic        o_stall,
  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_sel,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMAX  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off;
  logic [1:0]       size;
  logic             we;
  logic             aligned, expired;
  logic             start, bad, fin, fin_fault;

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] o);
    logic [31:0] r;
    case (sz)
      2'b00:   r = d >> {o, 3'b000};
      2'b01:   r = d >> {o[1], 4'b0000};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    case (i_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_addr[0];
      2'b10:   aligned = (i_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == TMAX[CNT_W-1:0]);
  assign o_stall = (state != IDLE) | i_req;

  // Misaligned requests complete straight from IDLE, so the done cycle always sees IDLE.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    bad       = 1'b0;
    fin       = 1'b0;
    fin_fault = 1'b0;
    case (state)
      IDLE: begin
        if (i_req) begin
          if (aligned) begin
            start     = 1'b1;
            state_nxt = BUSY;
          end else begin
            bad = 1'b1;
          end
        end
      end
      BUSY: begin
        if (i_bus_err) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end else if (i_bus_ack) begin
          fin = 1'b1;
        end else if (expired) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end
        if (fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      off         <= 2'b00;
      size        <= 2'b00;
      we          <= 1'b0;
      o_rdata     <= '0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      o_bus_cyc   <= 1'b0;
      o_bus_stb   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_sel   <= 4'b0000;
    end else begin
      state   <= state_nxt;
      o_done  <= fin | bad;
      o_fault <= fin_fault | bad;
      if (start) begin
        o_bus_cyc   <= 1'b1;
        o_bus_stb   <= 1'b1;
        o_bus_we    <= i_we;
        o_bus_addr  <= {i_addr[31:2], 2'b00};
        o_bus_wdata <= i_wdata;
        o_bus_sel   <= i_we ? i_wmask : 4'b1111;
        off         <= i_addr[1:0];
        size        <= i_size;
        we          <= i_we;
        cnt         <= '0;
      end else if (state == BUSY && !fin) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fin) begin
        o_bus_cyc <= 1'b0;
        o_bus_stb <= 1'b0;
        o_bus_we  <= 1'b0;
        o_bus_sel <= 4'b0000;
        o_rdata   <= (fin_fault || we) ? 32'h0 : align_load(i_bus_rdata, size, off);
      end
      if (bad) o_rdata <= 32'h0;
    end
  end

endmodule

// File: tb/tb_asrv32_dmem_interface.sv
// Directed bench for asrv32_dmem_interface with a hand-driven slave and a 4-cycle timeout.
module tb_asrv32_dmem_interface;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = 2'b00;
  logic [3:0]  wmask = 4'b0000;
  logic [31:0] rdata;
  logic        done, fault, stall;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] bus_rdata = '0;
  int checks = 0;
  int failures = 0;

  asrv32_dmem_interface #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_size(size),
    .i_wdata(wdata), .i_wmask(wmask), .o_rdata(rdata), .o_done(done), .o_fault(fault),
    .o_stall(stall), .o_bus_cyc(bus_cyc), .o_bus_stb(bus_stb), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_sel(bus_sel),
    .i_bus_ack(ack), .i_bus_err(err), .i_bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns one cycle after the accepting edge.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] m);
    req = 1'b1; we = w; addr = a; size = s; wdata = d; wmask = m;
    #1;
    chk("stall_on_req", {31'b0, stall}, 32'd1);
    step();
    req = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_cyc", {31'b0, bus_cyc}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Word load, zero wait states
    do_req(1'b0, 32'h0000_1000, 2'b10, 32'h0, 4'h0);
    chk("wl_cyc", {31'b0, bus_cyc}, 32'd1);
    chk("wl_stb", {31'b0, bus_stb}, 32'd1);
    chk("wl_addr", bus_addr, 32'h0000_1000);
    chk("wl_sel", {28'b0, bus_sel}, 32'hF);
    chk("wl_we", {31'b0, bus_we}, 32'd0);
    chk("wl_nodone", {31'b0, done}, 32'd0);
    ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    ack = 1'b0;
    chk("wl_done", {31'b0, done}, 32'd1);
    chk("wl_fault", {31'b0, fault}, 32'd0);
    chk("wl_rdata", rdata, 32'hDEAD_BEEF);
    chk("wl_cyc_drop", {31'b0, bus_cyc}, 32'd0);
    chk("wl_stall_done", {31'b0, stall}, 32'd0);
    step();
    chk("wl_pulse", {31'b0, done}, 32'd0);
    chk("wl_hold", rdata, 32'hDEAD_BEEF);

    // Byte load, 3 wait states; ack lands in the timeout expiry cycle and still succeeds
    do_req(1'b0, 32'h0000_1003, 2'b00, 32'h0, 4'h0);
    bus_rdata = 32'hA1B2_C3D4;
    for (int i = 0; i < 3; i++) begin
      chk("bl_wait_cyc", {31'b0, bus_cyc}, 32'd1);
      chk("bl_wait_done", {31'b0, done}, 32'd0);
      step();
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("bl_done", {31'b0, done}, 32'd1);
    chk("bl_fault", {31'b0, fault}, 32'd0);
    chk("bl_rdata", rdata, 32'h0000_00A1);

    // Half load, then a store issued back-to-back in the done cycle
    step();
    do_req(1'b0, 32'h0000_1002, 2'b01, 32'h0, 4'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("hl_done", {31'b0, done}, 32'd1);
    chk("hl_rdata", rdata, 32'h0000_A1B2);
    req = 1'b1; we = 1'b1; addr = 32'h0000_2001; size = 2'b00;
    wdata = 32'h0000_AB00; wmask = 4'b0010;
    step();
    req = 1'b0;
    chk("st_cyc", {31'b0, bus_cyc}, 32'd1);
    chk("st_we", {31'b0, bus_we}, 32'd1);
    chk("st_sel", {28'b0, bus_sel}, 32'h2);
    chk("st_addr", bus_addr, 32'h0000_2000);
    chk("st_wdata", bus_wdata, 32'h0000_AB00);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("st_done", {31'b0, done}, 32'd1);
    chk("st_fault", {31'b0, fault}, 32'd0);
    chk("st_rdata", rdata, 32'h0);
    chk("st_we_drop", {31'b0, bus_we}, 32'd0);
    step();

    // Misaligned word and illegal size: fault one cycle later, no bus cycle
    do_req(1'b0, 32'h0000_3002, 2'b10, 32'h0, 4'h0);
    chk("mis_cyc", {31'b0, bus_cyc}, 32'd0);
    chk("mis_done", {31'b0, done}, 32'd1);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_rdata", rdata, 32'h0);
    step();
    do_req(1'b0, 32'h0000_4000, 2'b11, 32'h0, 4'h0);
    chk("ill_cyc", {31'b0, bus_cyc}, 32'd0);
    chk("ill_fault", {31'b0, fault}, 32'd1);
    step();

    // Silent slave: timeout after the 4th BUSY cycle
    do_req(1'b0, 32'h0000_5000, 2'b10, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_cyc", {31'b0, bus_cyc}, 32'd1);
      chk("to_wait_done", {31'b0, done}, 32'd0);
      step();
    end
    chk("to_done", {31'b0, done}, 32'd1);
    chk("to_fault", {31'b0, fault}, 32'd1);
    chk("to_cyc", {31'b0, bus_cyc}, 32'd0);
    chk("to_rdata", rdata, 32'h0);
    step();

    // Simultaneous ack and err: error wins
    do_req(1'b0, 32'h0000_6000, 2'b10, 32'h0, 4'h0);
    ack = 1'b1; err = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    ack = 1'b0; err = 1'b0;
    chk("ae_done", {31'b0, done}, 32'd1);
    chk("ae_fault", {31'b0, fault}, 32'd1);
    chk("ae_rdata", rdata, 32'h0);
    step();

    // Reset during BUSY, stray ack afterwards, then a normal request
    do_req(1'b0, 32'h0000_7000, 2'b10, 32'h0, 4'h0);
    chk("rb_cyc", {31'b0, bus_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_cyc_async", {31'b0, bus_cyc}, 32'd0);
    chk("rb_stb_async", {31'b0, bus_stb}, 32'd0);
    step();
    rst_n = 1'b1;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rb_nodone", {31'b0, done}, 32'd0);
    chk("rb_stray_cyc", {31'b0, bus_cyc}, 32'd0);
    do_req(1'b0, 32'h0000_8004, 2'b10, 32'h0, 4'h0);
    chk("rb_new_addr", bus_addr, 32'h0000_8004);
    ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    ack = 1'b0;
    chk("rb_new_done", {31'b0, done}, 32'd1);
    chk("rb_new_fault", {31'b0, fault}, 32'd0);
    chk("rb_new_rdata", rdata, 32'hCAFE_F00D);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
